// File: rtl/alu_pipe.sv
// WIDTH-bit pipelined ALU: single-cycle logic/arithmetic ops with a registered result,
// plus an iterative shift-add multiplier, behind valid/ready handshakes on both sides.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
  // The source holds a/b/op while in_valid && !in_ready; the result holds while
  // out_valid && !out_ready.

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t state, state_next;

  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic               b_inv;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [WIDTH-1:0]   low_sum;
  logic               add_ovf;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt;

  assign accept   = in_valid && in_ready;
  assign is_mul   = (op == OP_MUL);
  assign mul_done = (state == BUSY) && (cnt == CW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = is_mul ? BUSY : FULL;
      BUSY:    if (mul_done) state_next = FULL;
      FULL: begin
        if (out_ready) begin
          if (in_valid) state_next = is_mul ? BUSY : FULL;
          else          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == IDLE) || ((state == FULL) && out_ready);
    out_valid = (state == FULL);
    state_dbg = state;
  end

  // One shared adder; the carry into the MSB comes from the low WIDTH-1 bits.
  always_comb begin
    b_inv         = (op == OP_SUB) || (op == OP_SLT);
    b_eff         = b_inv ? ~b : b;
    {cout, sum}   = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(b_inv);
    low_sum       = {1'b0, a[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]} + WIDTH'(b_inv);
    add_ovf       = low_sum[WIDTH-1] ^ cout;
  end

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOR: alu_res = ~(a | b);
      OP_ADD: begin alu_res = sum; alu_ovf = add_ovf; end
      OP_SUB: begin alu_res = sum; alu_ovf = add_ovf; end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      default: alu_res = '0;
    endcase
  end

  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  // Datapath: output register and multiplier iteration state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (is_mul) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= CW'(WIDTH);
      end else begin
        result <= alu_res;
        zero   <= (alu_res == '0);
        ovf    <= alu_ovf;
      end
    end else if (state == BUSY) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (mul_done) begin
        result <= acc_next[WIDTH-1:0];
        zero   <= (acc_next[WIDTH-1:0] == '0);
        ovf    <= |acc_next[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scenario-driven bench for alu_pipe (WIDTH=8) with a reference model feeding an
// expected-result queue that is drained as outputs transfer.
module tb_alu_pipe;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  logic [1:0]   state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rand_bp = 0;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] mon_exp;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: returns {result, zero, ovf}
  function automatic logic [W+1:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    longint sx, sy, ux, uy, s, p, lo, hi;
    logic [W-1:0] r;
    logic v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    lo = -(longint'(1) <<< (W-1));
    hi = (longint'(1) <<< (W-1)) - 1;
    r = '0;
    v = 1'b0;
    case (o)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b1100: r = ~(x | y);
      4'b0010: begin s = sx + sy; r = W'(s); v = (s > hi) || (s < lo); end
      4'b0110: begin s = sx - sy; r = W'(s); v = (s > hi) || (s < lo); end
      4'b0111: r = (sx < sy) ? W'(1) : W'(0);
      4'b1000: begin p = ux * uy; r = W'(p); v = ((p >> W) != 0); end
      default: r = '0;
    endcase
    return {r, (r == '0), v};
  endfunction

  // Scoreboard: one comparison per output transfer
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got result=%h zero=%b ovf=%b, required no output",
                 result, zero, ovf);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({result, zero, ovf} !== mon_exp) begin
          errors++;
          $display("FAIL out_data: got result=%h zero=%b ovf=%b, required result=%h zero=%b ovf=%b",
                   result, zero, ovf, mon_exp[W+1:2], mon_exp[1], mon_exp[0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  end

  // Driver: present an op, wait for acceptance, return 1 time unit after the accepting edge
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit push);
    int n = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
      in_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, result, zero, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b result=%h zero=%b ovf=%b, required all 0",
               out_valid, result, zero, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_ready: got in_ready=%b state=%0d, required 1 and 0", in_ready, state_dbg);
    end
  endtask

  task automatic test_add();
    issue(4'b0010, 8'h7F, 8'h01, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || result !== 8'h80 || ovf !== 1'b1 || zero !== 1'b0) begin
      errors++;
      $display("FAIL add_ovf: got valid=%b result=%h zero=%b ovf=%b, required 1 80 0 1",
               out_valid, result, zero, ovf);
    end
    issue(4'b0010, 8'hFF, 8'h01, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || result !== 8'h00 || ovf !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: got valid=%b result=%h zero=%b ovf=%b, required 1 00 1 0",
               out_valid, result, zero, ovf);
    end
    wait_drain();
  endtask

  task automatic test_sub_slt();
    issue(4'b0110, 8'h05, 8'h05, 1'b1);
    checks++;
    if (result !== 8'h00 || zero !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_zero: got result=%h zero=%b ovf=%b, required 00 1 0", result, zero, ovf);
    end
    issue(4'b0111, 8'h80, 8'h01, 1'b1);
    checks++;
    if (result !== 8'h01 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL slt_neg: got result=%h ovf=%b, required 01 0", result, ovf);
    end
    issue(4'b0111, 8'h01, 8'h80, 1'b1);
    checks++;
    if (result !== 8'h00 || zero !== 1'b1) begin
      errors++;
      $display("FAIL slt_pos: got result=%h zero=%b, required 00 1", result, zero);
    end
    wait_drain();
  endtask

  task automatic test_mul();
    int bad;
    issue(4'b1000, 8'h10, 8'h10, 1'b1);
    bad = 0;
    for (int i = 1; i < W; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mul_busy: %0d busy cycles with out_valid or in_ready high, required 0", bad);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 8'h00 || ovf !== 1'b1 || zero !== 1'b1) begin
      errors++;
      $display("FAIL mul_latency: got valid=%b result=%h zero=%b ovf=%b at edge %0d, required 1 00 1 1",
               out_valid, result, zero, ovf, W);
    end
    issue(4'b1000, 8'h0F, 8'h03, 1'b1);
    wait_drain();
    checks++;
    if (result !== 8'h2D || ovf !== 1'b0) begin
      errors++;
      $display("FAIL mul_small: got result=%h ovf=%b, required 2d 0", result, ovf);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    issue(4'b0010, 8'h01, 8'h02, 1'b1);
    issue(4'b0000, 8'hF0, 8'h0F, 1'b1);
    issue(4'b1100, 8'h0F, 8'h30, 1'b1);
    issue(4'b0110, 8'h10, 8'h20, 1'b1);
    checks++;
    if (cyc - c0 != 4) begin
      errors++;
      $display("FAIL back_to_back: 4 ops took %0d cycles, required 4", cyc - c0);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int bad;
    out_ready = 1'b0;
    issue(4'b0000, 8'hF0, 8'h3C, 1'b1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (result !== 8'h30 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d stalled cycles unstable, required result=30 valid=1 in_ready=0", bad);
    end
    out_ready = 1'b1;
    issue(4'b0001, 8'h01, 8'h02, 1'b1);
    checks++;
    if (result !== 8'h03 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_poppush: got result=%h valid=%b, required 03 1", result, out_valid);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid_mul();
    issue(4'b1000, 8'h0F, 8'h03, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (state_dbg !== 2'd1) begin
      errors++;
      $display("FAIL rst_busy: got state=%0d, required 1", state_dbg);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, result, zero, ovf} !== '0) begin
      errors++;
      $display("FAIL rst_mid_mul: got valid=%b result=%h zero=%b ovf=%b, required all 0",
               out_valid, result, zero, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got in_ready=%b, required 1", in_ready);
    end
    issue(4'b0010, 8'h02, 8'h03, 1'b1);
    checks++;
    if (result !== 8'h05 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_fresh_add: got result=%h valid=%b, required 05 1", result, out_valid);
    end
    wait_drain();
  endtask

  task automatic test_unsupported();
    issue(4'b0101, 8'hAA, 8'h55, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || result !== 8'h00 || zero !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL unsupported: got valid=%b result=%h zero=%b ovf=%b, required 1 00 1 0",
               out_valid, result, zero, ovf);
    end
    wait_drain();
  endtask

  task automatic test_random();
    logic [3:0] ops [8];
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110;
    ops[4] = 4'b0111; ops[5] = 4'b1100; ops[6] = 4'b1000; ops[7] = 4'b1011;
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(ops[$urandom_range(0, 7)], W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b1);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    op = '0;
    test_reset();
    test_add();
    test_sub_slt();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mul();
    test_unsupported();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised WIDTH-bit integer ALU for the pipelined datapath, succeeding the 1-bit ripple slice. Single-cycle logic and arithmetic ops (AND, OR, NOR, ADD, SUB, SLT) return a result registered one cycle after acceptance. MUL is iterative shift-add over WIDTH cycles. Valid/ready handshakes on input and output let the execute stage stall the block and let the block stall issue.

## Interface
- WIDTH, 32: operand/result width in bits; any value ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block accepts; transfer when in_valid && in_ready at a rising edge.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MUL; any other code is unsupported.
- out_valid  out  1  result, zero and ovf are valid.
- out_ready  in  1  consumer takes the result; transfer when out_valid && out_ready.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- ovf  out  1  overflow flag, defined per op below.

## Operation
- States:
  - IDLE: output register empty.
  - BUSY: MUL iterating.
  - FULL: output register holds a result.
- in_ready = (IDLE) || (FULL && out_ready). It is 0 in BUSY.
- Accepting a single-cycle op: capture result, zero and ovf, then go to FULL.
- Accepting MUL:
  - Latch a (multiplicand) and b (multiplier), clear a 2·WIDTH accumulator, load a step counter with WIDTH, go to BUSY.
  - Each BUSY cycle adds the shifted multiplicand when the current multiplier bit is 1, then decrements the counter.
  - When the counter reaches 0: load the output register, go to FULL.
- FULL && out_ready && !in_valid: go to IDLE.
- FULL && out_ready && in_valid: pop and push in the same edge. Go to FULL (single-cycle op) or BUSY (MUL).
- FULL && !out_ready: result, zero and ovf hold stable.
- Arithmetic:
  - ADD/SUB/SLT use one WIDTH-bit adder. SUB and SLT compute a + ~b + 1.
  - ovf for ADD/SUB: signed overflow = carry into MSB XOR carry out of MSB.
  - SLT: result = {WIDTH-1 zeros, sum[MSB] ^ ovf}. This is the correct signed a < b; reported ovf = 0.
  - AND/OR/NOR: bitwise; ovf = 0.
  - MUL: result = low WIDTH bits of the unsigned product; ovf = 1 iff the high WIDTH bits are non-zero.
  - Unsupported op: accepted as a single-cycle op; result = 0, zero = 1, ovf = 0.
- zero is always computed from the registered result.

## Timing
- Reset (async assert, any state, including mid-MUL):
  - state = IDLE; out_valid = 0; result = 0; zero = 0; ovf = 0.
  - Any in-progress MUL is discarded.
  - in_ready = 1 from the first edge after deassertion.
- Single-cycle op accepted at edge k: out_valid = 1 and the result is visible immediately after edge k (latency 1).
- MUL accepted at edge k:
  - BUSY occupies edges k+1 … k+WIDTH.
  - out_valid = 1 immediately after edge k+WIDTH (latency WIDTH).
  - in_ready = 0 throughout.
- Throughput:
  - Single-cycle ops: one per cycle while out_ready = 1.
  - MUL: one per WIDTH+1 cycles at best, since in_ready is 0 while BUSY.
- in_valid while in_ready = 0: operands are ignored and not captured. The source must hold them.
- out_valid never drops without a transfer, except on reset.

## Test plan
- WIDTH=8, out_ready=1:
  - ADD a=0x7F, b=0x01 -> result 0x80, ovf 1, zero 0, one cycle after acceptance.
  - ADD a=0xFF, b=0x01 -> result 0x00, ovf 0, zero 1.
- SUB a=0x05, b=0x05 -> result 0x00, zero 1, ovf 0. SLT a=0x80, b=0x01 -> result 0x01, ovf 0. SLT a=0x01, b=0x80 -> result 0x00.
- MUL (WIDTH=8):
  - a=0x10, b=0x10 -> result 0x00, ovf 1, zero 1, out_valid exactly 8 edges after acceptance, in_ready 0 throughout.
  - a=0x0F, b=0x03 -> result 0x2D, ovf 0.
- Backpressure: issue AND 0xF0/0x3C with out_ready=0 for 5 cycles.
  - result 0x30 holds stable; in_ready stays 0.
  - Raise out_ready while in_valid carries OR 0x01/0x02: same-edge pop/push, next result 0x03.
- Reset mid-MUL: assert rst_n=0 at BUSY step 3.
  - All outputs 0 immediately.
  - After release, in_ready=1 and a fresh ADD 0x02+0x03 returns 0x05.
- Unsupported op 0101 with a=0xAA, b=0x55 -> result 0x00, zero 1, ovf 0, latency 1.
